morse_tx_sequencer: RTL and testbench

Sequences Morse transmission of queued 3-bit letter codes onto a single output bit. The block buffers requested letters in a small FIFO and drives the letter-to-pattern lookup table through `code_sel`/`code_in`. It serialises each 16-bit pattern MSB-first at one symbol per tick from an internal tick divider, then inserts an inter-letter gap. It sits between the switch/key front end and the LED output, and replaces free-running load/shift control with a handshaked scheduler.

---
 rtl/morse_tx_sequencer.sv | 153 +++++++++++++++
 tb/tb_morse_tx_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/morse_tx_sequencer.sv
// Morse transmit sequencer: queues 3-bit letter codes, fetches each 16-bit
// pattern from an external LUT and shifts it out MSB-first, one symbol per tick.
module morse_tx_sequencer #(
  parameter int TICK_DIV  = 25000000,
  parameter int GAP_TICKS = 3,
  parameter int DEPTH     = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  letter_in,
  input  logic        letter_valid,
  output logic        letter_ready,
  input  logic        flush,
  output logic [2:0]  code_sel,
  input  logic [15:0] code_in,
  output logic        morse_out,
  output logic        busy,
  output logic        done
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int GAP_W = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  localparam logic [CNT_W-1:0] FULL      = CNT_W'(DEPTH);
  localparam logic [27:0]      TICK_LAST = 28'(TICK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_TICKS - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} state_t;

  state_t           state, state_n;
  logic [2:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, wr_ptr_n, rd_ptr, rd_ptr_n;
  logic [CNT_W-1:0] count, count_n;
  logic [27:0]      tick, tick_n;
  logic [3:0]       bit_cnt, bit_cnt_n;
  logic [GAP_W-1:0] gap_cnt, gap_cnt_n;
  logic [15:0]      sr, sr_n;
  logic [2:0]       code_sel_n;
  logic             morse_n, done_n;
  logic             push, pop, tick_last;

  assign letter_ready = (count != FULL);
  assign busy         = (state != IDLE) || (count != '0);
  assign push         = letter_valid && letter_ready && !flush;
  assign pop          = (state == IDLE) && (count != '0) && !flush;
  assign tick_last    = (tick == TICK_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      tick      <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      sr        <= '0;
      code_sel  <= '0;
      morse_out <= 1'b0;
      done      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      state     <= state_n;
      wr_ptr    <= wr_ptr_n;
      rd_ptr    <= rd_ptr_n;
      count     <= count_n;
      tick      <= tick_n;
      bit_cnt   <= bit_cnt_n;
      gap_cnt   <= gap_cnt_n;
      sr        <= sr_n;
      code_sel  <= code_sel_n;
      morse_out <= morse_n;
      done      <= done_n;
      if (push) mem[wr_ptr] <= letter_in;
    end
  end

  always_comb begin
    state_n    = state;
    wr_ptr_n   = push ? wr_ptr + PTR_W'(1) : wr_ptr;
    rd_ptr_n   = pop  ? rd_ptr + PTR_W'(1) : rd_ptr;
    count_n    = count;
    tick_n     = tick;
    bit_cnt_n  = bit_cnt;
    gap_cnt_n  = gap_cnt;
    sr_n       = sr;
    code_sel_n = code_sel;
    done_n     = 1'b0;
    morse_n    = 1'b0;

    if (push && !pop)      count_n = count + CNT_W'(1);
    else if (pop && !push) count_n = count - CNT_W'(1);

    case (state)
      IDLE: begin
        if (count != '0) begin
          code_sel_n = mem[rd_ptr];
          state_n    = LOAD;
        end
      end
      LOAD: begin
        sr_n      = code_in;
        tick_n    = '0;
        bit_cnt_n = '0;
        state_n   = SEND;
      end
      SEND: begin
        if (tick_last) begin
          tick_n    = '0;
          sr_n      = {sr[14:0], 1'b0};
          bit_cnt_n = bit_cnt + 4'd1;
          if (bit_cnt == 4'd15) begin
            gap_cnt_n = '0;
            state_n   = GAP;
          end
        end else begin
          tick_n = tick + 28'd1;
        end
      end
      GAP: begin
        if (tick_last) begin
          tick_n    = '0;
          gap_cnt_n = gap_cnt + GAP_W'(1);
          if (gap_cnt == GAP_LAST) begin
            gap_cnt_n = '0;
            done_n    = 1'b1;
            state_n   = IDLE;
          end
        end else begin
          tick_n = tick + 28'd1;
        end
      end
      default: state_n = IDLE;
    endcase

    // Abort wins over everything except reset; the queued letters are dropped.
    if (flush) begin
      state_n   = IDLE;
      wr_ptr_n  = '0;
      rd_ptr_n  = '0;
      count_n   = '0;
      tick_n    = '0;
      bit_cnt_n = '0;
      gap_cnt_n = '0;
      sr_n      = '0;
      done_n    = 1'b0;
    end

    // Output is registered from the next shift-register MSB so each symbol lines up with its state.
    morse_n = (state_n == SEND) ? sr_n[15] : 1'b0;
  end

endmodule

// File: tb/tb_morse_tx_sequencer.sv
// Directed bench for morse_tx_sequencer with a LUT model and a scoreboard of
// expected 16-bit patterns reconstructed from the serial output at each done pulse.
module tb_morse_tx_sequencer;
  localparam int TD    = 4;
  localparam int GT    = 1;
  localparam int DEPTH = 4;
  localparam int LAT   = (16 + GT) * TD;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  letter_in;
  logic        letter_valid;
  logic        letter_ready;
  logic        flush;
  logic [2:0]  code_sel;
  logic [15:0] code_in;
  logic        morse_out;
  logic        busy;
  logic        done;
  logic        corrupt;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] sb [$];
  logic [127:0] hist = '0;

  morse_tx_sequencer #(.TICK_DIV(TD), .GAP_TICKS(GT), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .letter_in(letter_in), .letter_valid(letter_valid),
    .letter_ready(letter_ready), .flush(flush), .code_sel(code_sel), .code_in(code_in),
    .morse_out(morse_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lut(input logic [2:0] s);
    case (s)
      3'd0: lut = 16'hA800;
      3'd1: lut = 16'hE000;
      3'd2: lut = 16'hAE00;
      3'd3: lut = 16'hAB80;
      3'd4: lut = 16'hBB80;
      3'd5: lut = 16'hEAE0;
      3'd6: lut = 16'hEBA0;
      default: lut = 16'hEEA0;
    endcase
  endfunction

  assign code_in = lut(code_sel) ^ (corrupt ? 16'hFFFF : 16'h0000);

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Rebuild the letter from the output history: first and last cycle of every symbol, then the gap.
  always @(negedge clk) begin : monitor
    logic [15:0] obs_first, obs_last, exp_pat;
    hist = {hist[126:0], morse_out};
    if (done) begin
      if (sb.size() == 0) begin
        checkOutput("done_unexpected", {31'b0, done}, 32'd0);
      end else begin
        exp_pat = sb.pop_front();
        for (int k = 0; k < 16; k++) begin
          obs_first[15-k] = hist[LAT - TD*k];
          obs_last[15-k]  = hist[LAT - TD*k - (TD-1)];
        end
        checkOutput("stream_first_cycle", {16'b0, obs_first}, {16'b0, exp_pat});
        checkOutput("stream_last_cycle",  {16'b0, obs_last},  {16'b0, exp_pat});
        checkOutput("gap_low", 32'(hist[GT*TD:1]), 32'd0);
      end
    end
  end

  task automatic applyStimulus(input logic [2:0] l);
    int guard = 0;
    letter_in    = l;
    letter_valid = 1'b1;
    while (!letter_ready && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("ready_wait", {31'b0, letter_ready}, 32'd1);
    if (letter_ready) sb.push_back(lut(l));
    @(negedge clk);
    letter_valid = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int g = 0;
    while (!done && g < bound) begin
      @(negedge clk);
      g++;
    end
    checkOutput("done_seen", {31'b0, done}, 32'd1);
  endtask

  task automatic wait_idle(input int bound);
    int g = 0;
    while ((busy || sb.size() != 0) && g < bound) begin
      @(negedge clk);
      g++;
    end
    checkOutput("idle_reached", {31'b0, busy}, 32'd0);
    checkOutput("scoreboard_drained", sb.size(), 32'd0);
  endtask

  initial begin
    reset        = 1'b1;
    letter_in    = '0;
    letter_valid = 1'b0;
    flush        = 1'b0;
    corrupt      = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_morse", {31'b0, morse_out}, 32'd0);
    checkOutput("rst_done", {31'b0, done}, 32'd0);
    checkOutput("rst_ready", {31'b0, letter_ready}, 32'd1);
    checkOutput("rst_busy", {31'b0, busy}, 32'd0);
    checkOutput("rst_code_sel", {29'b0, code_sel}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] single letter cycle timing");
    applyStimulus(3'd1);
    for (int c = 1; c <= 71; c++) begin
      @(negedge clk);
      if (c == 1)  checkOutput("t1_load_low", {31'b0, morse_out}, 32'd0);
      if (c == 2)  checkOutput("t1_first_symbol", {31'b0, morse_out}, 32'd1);
      if (c == 13) checkOutput("t1_last_high", {31'b0, morse_out}, 32'd1);
      if (c == 14) checkOutput("t1_first_low", {31'b0, morse_out}, 32'd0);
      if (c == 69) checkOutput("t1_done_early", {31'b0, done}, 32'd0);
      if (c == 69) checkOutput("t1_busy_gap", {31'b0, busy}, 32'd1);
      if (c == 70) checkOutput("t1_done_pulse", {31'b0, done}, 32'd1);
      if (c == 70) checkOutput("t1_busy_fall", {31'b0, busy}, 32'd0);
      if (c == 71) checkOutput("t1_done_single", {31'b0, done}, 32'd0);
    end

    $display("[TB] back-to-back letters and backpressure");
    applyStimulus(3'd0);
    applyStimulus(3'd2);
    applyStimulus(3'd3);
    applyStimulus(3'd4);
    applyStimulus(3'd5);
    checkOutput("t2_full_ready_low", {31'b0, letter_ready}, 32'd0);
    wait_done(200);
    checkOutput("t2_ready_low_at_done", {31'b0, letter_ready}, 32'd0);
    @(negedge clk);
    checkOutput("t2_ready_after_pop", {31'b0, letter_ready}, 32'd1);
    applyStimulus(3'd1);
    wait_idle(2000);

    $display("[TB] flush during SEND");
    applyStimulus(3'd6);
    applyStimulus(3'd0);
    applyStimulus(3'd3);
    repeat (20) @(negedge clk);
    flush        = 1'b1;
    letter_in    = 3'd2;
    letter_valid = 1'b1;
    @(negedge clk);
    flush        = 1'b0;
    letter_valid = 1'b0;
    sb.delete();
    checkOutput("t3_morse", {31'b0, morse_out}, 32'd0);
    checkOutput("t3_busy", {31'b0, busy}, 32'd0);
    checkOutput("t3_ready", {31'b0, letter_ready}, 32'd1);
    checkOutput("t3_done", {31'b0, done}, 32'd0);
    repeat (150) @(negedge clk);
    checkOutput("t3_still_idle", {31'b0, busy}, 32'd0);

    $display("[TB] asynchronous reset during GAP");
    applyStimulus(3'd3);
    repeat (67) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("t4_morse", {31'b0, morse_out}, 32'd0);
    checkOutput("t4_done", {31'b0, done}, 32'd0);
    checkOutput("t4_ready", {31'b0, letter_ready}, 32'd1);
    checkOutput("t4_busy", {31'b0, busy}, 32'd0);
    checkOutput("t4_code_sel", {29'b0, code_sel}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    @(negedge clk);
    applyStimulus(3'd7);
    wait_idle(500);

    $display("[TB] LUT changes during SEND are ignored");
    applyStimulus(3'd4);
    repeat (5) @(negedge clk);
    corrupt = 1'b1;
    wait_done(200);
    @(negedge clk);
    corrupt = 1'b0;
    wait_idle(500);

    $display("[TB] simultaneous push and pop at count 2");
    applyStimulus(3'd0);
    applyStimulus(3'd2);
    applyStimulus(3'd5);
    for (int i = 0; i < 2*DEPTH; i++) begin
      wait_done(200);
      applyStimulus(3'(i + 1));
    end
    wait_idle(3000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not complete, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
